// File: rtl/acc_io_pkg.sv
// Shared address map, status bit positions and status word layout for the accumulator I/O bridge.
package acc_io_pkg;

    localparam logic [15:0] DATA_ADDR_DEF = 16'hFFFE;
    localparam logic [15:0] STAT_ADDR_DEF = 16'hFFFC;

    localparam int ST_HOLD  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_IRQEN = 4;

    typedef struct packed {
        logic [10:0] rsvd_hi;
        logic        irq_en;
        logic        rsvd_3;
        logic        overflow;
        logic        fifo_full;
        logic        hold_full;
    } stat_t;

    function automatic stat_t make_stat(input logic hold_full, input logic fifo_full,
                                        input logic overflow, input logic irq_en);
        stat_t s;
        s           = '0;
        s.hold_full = hold_full;
        s.fifo_full = fifo_full;
        s.overflow  = overflow;
        s.irq_en    = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/acc_io_bridge_if.sv
// CPU memory-stage bus plus peripheral in/out handshakes seen by the I/O bridge.
interface acc_io_bridge_if;
    logic [15:0] addr;
    logic        we;
    logic        re;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output addr, we, re, wdata, out_ready, in_data, in_valid,
        input  rdata, out_data, out_valid, in_ready
    );

    modport slave (
        input  addr, we, re, wdata, out_ready, in_data, in_valid,
        output rdata, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/acc_io_bridge_fifo.sv
// Output queue for the I/O bridge: power-of-two depth, head word visible combinationally.
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/acc_io_bridge.sv
// Memory-mapped I/O bridge: DATA/STAT decode, input holding register, output FIFO.
// Optional interrupt output compiled in with ACC_IO_IRQ_EN.
module acc_io_bridge
    import acc_io_pkg::*;
#(
    parameter int          OUT_DEPTH    = 4,
    parameter logic [15:0] IO_DATA_ADDR = DATA_ADDR_DEF,
    parameter logic [15:0] IO_STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic            CLK,
    input  logic            Reset,
    acc_io_bridge_if.slave  bus
`ifdef ACC_IO_IRQ_EN
    ,
    output logic            io_irq
`endif
);
    logic        data_hit, stat_hit;
    logic        wr_data, wr_stat, rd_data, rd_stat, rd_miss;
    logic        fifo_full, fifo_empty, drain, capture;
    logic        irq_en;
    logic [15:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        ovf_q, ovf_d;
    logic [15:0] rdata_q, rdata_d;

    assign data_hit = (bus.addr == IO_DATA_ADDR);
    assign stat_hit = (bus.addr == IO_STAT_ADDR);
    assign wr_data  = bus.we & data_hit;
    assign wr_stat  = bus.we & stat_hit;
    assign rd_data  = bus.re & data_hit;
    assign rd_stat  = bus.re & stat_hit;
    assign rd_miss  = bus.re & ~data_hit & ~stat_hit;
    assign drain    = ~fifo_empty & bus.out_ready;
    assign capture  = bus.in_valid & ~hold_full_q;

    io_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(16)) u_out_fifo (
        .CLK   (CLK),
        .Reset (Reset),
        .push  (wr_data),
        .pop   (bus.out_ready),
        .wdata (bus.wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (bus.out_data)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.in_ready  = ~hold_full_q;
    assign bus.rdata     = rdata_q;

    // Reads see the pre-edge state, so a same-cycle write to the same address is not visible yet.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovf_d       = ovf_q;
        rdata_d     = rdata_q;
        if (rd_data) begin
            rdata_d     = hold_full_q ? hold_q : 16'h0000;
            hold_full_d = 1'b0;
        end else if (rd_stat) begin
            rdata_d = make_stat(hold_full_q, fifo_full, ovf_q, irq_en);
        end else if (rd_miss) begin
            rdata_d = 16'h0000;
        end
        if (capture) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
        end
        if (wr_data & fifo_full & ~drain) ovf_d = 1'b1;
        if (wr_stat & bus.wdata[ST_OVF])  ovf_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovf_q       <= ovf_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef ACC_IO_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic io_irq_q;

    assign irq_en   = irq_en_q;
    assign irq_en_d = wr_stat ? bus.wdata[ST_IRQEN] : irq_en_q;
    assign io_irq   = io_irq_q;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            irq_en_q <= 1'b0;
            io_irq_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            io_irq_q <= irq_en_q & (hold_full_q | ovf_q);
        end
    end
`else
    assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_acc_io_bridge.sv
// Directed vector bench for acc_io_bridge; the IRQ sequence runs when ACC_IO_IRQ_EN is defined.
module tb_acc_io_bridge;
    localparam logic [15:0] D = 16'hFFFE;
    localparam logic [15:0] S = 16'hFFFC;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        re;
        logic [15:0] wdata;
        logic        out_ready;
        logic        in_valid;
        logic [15:0] in_data;
        logic        chk_rd;
        logic [15:0] exp_rdata;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic        exp_ir;
    } vec_t;

    logic CLK = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t vq[$];

    acc_io_bridge_if bus ();
`ifdef ACC_IO_IRQ_EN
    logic io_irq;
`endif

    acc_io_bridge dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
`ifdef ACC_IO_IRQ_EN
        ,
        .io_irq(io_irq)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [15:0] a, input logic w, input logic r,
                                input logic [15:0] wd, input logic ordy, input logic iv,
                                input logic [15:0] id, input logic crd, input logic [15:0] erd,
                                input logic eov, input logic [15:0] eod, input logic eir);
        vec_t v;
        v.addr = a; v.we = w; v.re = r; v.wdata = wd; v.out_ready = ordy;
        v.in_valid = iv; v.in_data = id; v.chk_rd = crd; v.exp_rdata = erd;
        v.exp_ov = eov; v.exp_od = eod; v.exp_ir = eir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic w, input logic r, input logic [15:0] wd,
                         input logic ordy, input logic iv, input logic [15:0] id);
        @(negedge CLK);
        bus.addr = a; bus.we = w; bus.re = r; bus.wdata = wd;
        bus.out_ready = ordy; bus.in_valid = iv; bus.in_data = id;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        Reset = 1'b0;
        bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = '0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h00A5;

        for (int c = 0; c < 2; c++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("reset%0d in_ready", c), {15'b0, bus.in_ready}, 16'h0001);
            chk($sformatf("reset%0d out_valid", c), {15'b0, bus.out_valid}, 16'h0000);
            chk($sformatf("reset%0d rdata", c), bus.rdata, 16'h0000);
            $display("reset cycle %0d: in_ready=%b out_valid=%b rdata=%h", c, bus.in_ready, bus.out_valid, bus.rdata);
        end
        @(negedge CLK);
        Reset = 1'b1;

        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 1, 16'h00A5, 0, 16'h0000, 0, 16'h0000, 0));
        vq.push_back(mk(S, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 0));
        vq.push_back(mk(D, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h00A5, 0, 16'h0000, 1));
        vq.push_back(mk(D, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 1));
        vq.push_back(mk(D, 1, 0, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1));
        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1));
        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1));
        for (int k = 1; k <= 5; k++)
            vq.push_back(mk(D, 1, 0, 16'h0100 + 16'(k), 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0101, 1));
        vq.push_back(mk(S, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0101, 1));
        vq.push_back(mk(S, 1, 0, 16'h0004, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0101, 1));
        vq.push_back(mk(S, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0101, 1));
        vq.push_back(mk(16'h1234, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0101, 1));
        vq.push_back(mk(D, 1, 0, 16'hBEEF, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 1));
        vq.push_back(mk(S, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0102, 1));
        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0103, 1));
        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0104, 1));
        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'hBEEF, 1));
        vq.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1));
        for (int k = 1; k <= 5; k++)
            vq.push_back(mk(D, 1, 0, 16'h0200 + 16'(k), 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 1));
        vq.push_back(mk(S, 1, 1, 16'h0004, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0201, 1));
        vq.push_back(mk(S, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0201, 1));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].addr, vq[i].we, vq[i].re, vq[i].wdata, vq[i].out_ready, vq[i].in_valid, vq[i].in_data);
            chk($sformatf("v%0d in_ready", i), {15'b0, bus.in_ready}, {15'b0, vq[i].exp_ir});
            chk($sformatf("v%0d out_valid", i), {15'b0, bus.out_valid}, {15'b0, vq[i].exp_ov});
            if (vq[i].exp_ov) chk($sformatf("v%0d out_data", i), bus.out_data, vq[i].exp_od);
            if (vq[i].chk_rd) chk($sformatf("v%0d rdata", i), bus.rdata, vq[i].exp_rdata);
            $display("vec %0d: addr=%h we=%b re=%b wdata=%h ordy=%b iv=%b -> rdata=%h ov=%b od=%h ir=%b",
                     i, vq[i].addr, vq[i].we, vq[i].re, vq[i].wdata, vq[i].out_ready, vq[i].in_valid,
                     bus.rdata, bus.out_valid, bus.out_data, bus.in_ready);
        end

        // Reset while the queue is full and the peripheral is draining.
        @(negedge CLK);
        Reset = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("midreset out_valid", {15'b0, bus.out_valid}, 16'h0000);
        chk("midreset rdata", bus.rdata, 16'h0000);
        chk("midreset in_ready", {15'b0, bus.in_ready}, 16'h0001);
        $display("mid-transfer reset: out_valid=%b rdata=%h in_ready=%b", bus.out_valid, bus.rdata, bus.in_ready);
        @(negedge CLK);
        Reset = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("postreset out_valid", {15'b0, bus.out_valid}, 16'h0000);
        drive(S, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("postreset stat", bus.rdata, 16'h0000);
        $display("post-reset: out_valid=%b stat=%h", bus.out_valid, bus.rdata);

`ifdef ACC_IO_IRQ_EN
        drive(S, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000);
        chk("irq after enable", {15'b0, io_irq}, 16'h0000);
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A5);
        chk("irq on capture edge", {15'b0, io_irq}, 16'h0000);
        drive(S, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("irq after capture", {15'b0, io_irq}, 16'h0001);
        chk("irq stat", bus.rdata, 16'h0011);
        drive(D, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("irq pop rdata", bus.rdata, 16'h00A5);
        chk("irq on pop edge", {15'b0, io_irq}, 16'h0001);
        idle();
        chk("irq cleared", {15'b0, io_irq}, 16'h0000);
        $display("irq sequence: io_irq=%b", io_irq);
`else
        drive(S, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000);
        drive(S, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("stat irqen absent", bus.rdata, 16'h0000);
        $display("irq disabled build: stat=%h", bus.rdata);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
